// File: rtl/mul_pkg.sv
// Shared constants, Booth operation encoding and the column-major index helper
// for the 32x32 multiplier front end.
package mul_pkg;

  localparam int XW     = 32;
  localparam int PP_NUM = XW / 2 + 1;
  localparam int PROD_W = 2 * XW;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG2,
    NEG1
  } booth_op_e;

  // Bit i of column j lives at 17j+i in the flattened column-major bus.
  function automatic int col_bit(input int col, input int pp);
    return col * PP_NUM + pp;
  endfunction

endpackage

// File: rtl/booth_sel.sv
// One radix-4 Booth group: decodes a 3-bit window of the multiplier into a
// magnitude select (0, x, 2x) and a negate flag. Purely combinational.
module booth_sel
  import mul_pkg::*;
(
  input  logic [2:0]        code,
  input  logic [PROD_W-1:0] x_ext,
  output logic [PROD_W-1:0] mag_sel,
  output logic              neg
);

  booth_op_e op;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    op      = ZERO;
    mag_sel = '0;
    neg     = 1'b0;
    unique case (code)
      3'b001, 3'b010: op = POS1;
      3'b011:         op = POS2;
      3'b100:         op = NEG2;
      3'b101, 3'b110: op = NEG1;
      default:        op = ZERO;
    endcase
    case (op)
      POS1, NEG1: mag_sel = x_ext;
      POS2, NEG2: mag_sel = x_ext << 1;
      default:    mag_sel = '0;
    endcase
    neg = (op == NEG1) || (op == NEG2);
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator with column-major transpose and a
// single valid/ready output register feeding the per-column Wallace slices.
module booth_pp_gen
  import mul_pkg::*;
(
  input  logic                     mul_clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mul_signed,
  input  logic [XW-1:0]            x,
  input  logic [XW-1:0]            y,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PROD_W*PP_NUM-1:0] pp_col
);

  logic [PROD_W-1:0]        x_ext;
  logic [XW+2:0]            y_pad;
  logic [PROD_W-1:0]        mag  [PP_NUM];
  logic [PROD_W-1:0]        fold [PP_NUM];
  logic [PROD_W-1:0]        pp   [PP_NUM];
  logic [PP_NUM-1:0]        neg;
  logic [PROD_W*PP_NUM-1:0] pp_col_d;
  logic                     accept;

  // y_pad[0] is the implicit y_ext[-1] = 0 below the LSB group.
  assign x_ext = {{XW{mul_signed & x[XW-1]}}, x};
  assign y_pad = {{2{mul_signed & y[XW-1]}}, y, 1'b0};

  for (genvar i = 0; i < PP_NUM; i++) begin : g_grp
    booth_sel u_sel (
      .code    (y_pad[2*i+2:2*i]),
      .x_ext   (x_ext),
      .mag_sel (mag[i]),
      .neg     (neg[i])
    );

    // The +1 of group i-1's two's-complement negation rides in the empty
    // bit 2(i-1) of this group's shifted product.
    if (i == 0) begin : g_nofold
      assign fold[i] = '0;
    end else begin : g_fold
      assign fold[i] = {{(PROD_W-1){1'b0}}, neg[i-1]} << (2*i-2);
    end

    assign pp[i] = (({PROD_W{neg[i]}} ^ mag[i]) << (2*i)) | fold[i];
  end

  always_comb begin
    pp_col_d = '0;
    for (int j = 0; j < PROD_W; j++) begin
      for (int i = 0; i < PP_NUM; i++) begin
        pp_col_d[col_bit(j, i)] = pp[i][j];
      end
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      // NOTE: the wide data register is reset too, because downstream must
      // see an all-zero bus while in reset, not just a low valid.
      pp_col    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      pp_col    <= pp_col_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Group 16 only ever sees 000/111 (signed) or 000/001 (unsigned).
  a_neg16_never : assert property (@(posedge mul_clk) disable iff (!resetn)
                                   !neg[PP_NUM-1]);

endmodule

// File: tb/tb_booth_pp_gen.sv
// Scoreboard bench for booth_pp_gen: the driver pushes expected products on
// acceptance, a negedge monitor pops and compares the column sums.
module tb_booth_pp_gen;
  import mul_pkg::*;

  localparam int CW     = PROD_W * PP_NUM;
  localparam int BUDGET = 200;

  typedef struct {
    logic [63:0]   prod;
    bit            has_raw;
    logic [CW-1:0] raw;
  } exp_t;

  logic          mul_clk = 1'b0;
  logic          resetn;
  logic          in_valid, in_ready, mul_signed, flush, out_valid, out_ready;
  logic [31:0]   x, y;
  logic [CW-1:0] pp_col;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rdy_rand = 1'b0;
  exp_t sb[$];

  always #5 mul_clk = ~mul_clk;

  booth_pp_gen dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_signed (mul_signed),
    .x          (x),
    .y          (y),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pp_col     (pp_col)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] col_sum(input logic [CW-1:0] c);
    logic [63:0] s = '0;
    for (int j = 0; j < PROD_W; j++)
      for (int i = 0; i < PP_NUM; i++)
        if (c[j*PP_NUM+i]) s += (64'd1 << j);
    return s;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic exp_t mk(input logic [63:0] p);
    exp_t e;
    e.prod = p; e.has_raw = 1'b0; e.raw = '0;
    return e;
  endfunction

  // Called just after a posedge; holds the operands until accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
    x = a; y = b; mul_signed = s; in_valid = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      @(negedge mul_clk);
      if (in_ready && !flush) begin
        sb.push_back(e);
        @(posedge mul_clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge mul_clk); #1;
    end
    in_valid = 1'b0;
    check("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < BUDGET && sb.size() != 0; n++) begin
      @(posedge mul_clk); #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge mul_clk); #1;
  endtask

  always @(negedge mul_clk) begin
    if (resetn) begin
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out: got sum %h, expected no output", col_sum(pp_col));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("col_sum", col_sum(pp_col), e.prod);
          if (e.has_raw) begin
            int bad = 0;
            bit found = 1'b0;
            for (int j = 0; j < PROD_W; j++)
              if (!found && pp_col[j*PP_NUM +: PP_NUM] !== e.raw[j*PP_NUM +: PP_NUM]) begin
                bad = j; found = 1'b1;
              end
            check("pp_col_raw", 64'(pp_col[bad*PP_NUM +: PP_NUM]), 64'(e.raw[bad*PP_NUM +: PP_NUM]));
          end
        end
      end
    end
  end

  logic [31:0] va [12] = '{32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                           32'hFFFFFFFE, 32'hFFFFFFFF, 32'h12345678, 32'h0, 32'h1,
                           32'h80000000, 32'h80000000};
  logic [31:0] vb [12] = '{32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                           32'h3, 32'h2, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF,
                           32'h80000000, 32'hFFFFFFFF};
  logic        vs [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [63:0] vp [12] = '{64'h000000000000000F, 64'h0000000000000001, 64'hFFFFFFFE00000001,
                           64'h4000000000000000, 64'hC000000080000000, 64'hFFFFFFFFFFFFFFFA,
                           64'h00000001FFFFFFFE, 64'h0000000123456780, 64'h0000000000000000,
                           64'hFFFFFFFFFFFFFFFF, 64'h4000000000000000, 64'h0000000080000000};

  initial begin
    logic [CW-1:0] snap;
    exp_t e;
    resetn = 1'b0; in_valid = 1'b0; mul_signed = 1'b0; flush = 1'b0;
    out_ready = 1'b1; x = '0; y = '0;

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pp_col_any", 64'(|pp_col), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge mul_clk); @(posedge mul_clk); #1;
    resetn = 1'b1;

    // Directed vectors; two carry the exact expected column layout.
    for (int v = 0; v < 12; v++) begin
      e = mk(vp[v]);
      if (v == 0) begin
        // pp0 = 3, pp1 = 3<<2
        e.has_raw = 1'b1;
        e.raw[0] = 1'b1; e.raw[17] = 1'b1; e.raw[35] = 1'b1; e.raw[52] = 1'b1;
      end else if (v == 9) begin
        // pp0 = ~1 (negated x), pp1 bit 0 = folded +1
        e.has_raw = 1'b1;
        e.raw[1] = 1'b1;
        for (int j = 1; j < 64; j++) e.raw[17*j] = 1'b1;
      end
      send(va[v], vb[v], vs[v], e);
    end
    drain();

    // Backpressure: A held, B waits three cycles, then both move without loss.
    out_ready = 1'b0;
    send(32'd7, 32'd9, 1'b0, mk(64'd63));
    x = 32'd11; y = 32'd13; mul_signed = 1'b0; in_valid = 1'b1;
    @(negedge mul_clk);
    snap = pp_col;
    @(posedge mul_clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge mul_clk);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_stable", 64'(|(pp_col ^ snap)), 64'd0);
      @(posedge mul_clk); #1;
    end
    out_ready = 1'b1;
    send(32'd11, 32'd13, 1'b0, mk(64'd143));
    drain();

    // Flush with a held result and a pending operand.
    out_ready = 1'b0;
    send(32'd5, 32'd5, 1'b0, mk(64'd25));
    x = 32'd100; y = 32'd100; in_valid = 1'b1; flush = 1'b1;
    @(negedge mul_clk);
    check("flush_had_valid", 64'(out_valid), 64'd1);
    if (out_valid && sb.size() != 0) void'(sb.pop_front());
    @(posedge mul_clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_clears", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge mul_clk);
    #1;

    // Flush while idle: the operand must not be taken.
    x = 32'd200; y = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge mul_clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_no_accept", 64'(out_valid), 64'd0);
    repeat (3) @(posedge mul_clk);
    #1;
    send(32'd6, 32'hFFFFFFFF, 1'b1, mk(64'hFFFFFFFFFFFFFFFA));
    drain();

    // Asynchronous reset mid-operation discards the held result.
    out_ready = 1'b0;
    send(32'd9, 32'd9, 1'b0, mk(64'd81));
    #1 resetn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_pp_col_any", 64'(|pp_col), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge mul_clk); @(posedge mul_clk); #3;
    resetn = 1'b1;
    out_ready = 1'b1;
    send(32'd12, 32'd12, 1'b0, mk(64'd144));
    drain();

    // Random regression with random backpressure, both signedness modes.
    rdy_rand = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h7FFFFFFF;
        default: ;
      endcase
      send(a, b, s, mk(ref_mul(a, b, s)));
    end
    rdy_rand = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_pp_gen.md
# booth_pp_gen

Radix-4 Booth partial-product generator and column transposer for the 32x32 pipelined multiplier. It sits upstream of the per-column 17-input Wallace slices. It accepts operands through a valid/ready handshake and registers 17 Booth partial products, each 64 bits wide. The output is presented column-major, so each column's 17-bit slice feeds one Wallace slice directly.

## Interface
- `XW`, 32: operand width. Only 32 is supported.
- `PP_NUM`, 17: partial-product count, equal to XW/2+1.
- `PROD_W`, 64: product width, equal to 2*XW.
- `mul_clk`  in  1: clock, rising edge.
- `resetn`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: operands present.
- `in_ready`  out  1: block can accept an operand pair this cycle.
- `mul_signed`  in  1: 1 means signed x signed; 0 means unsigned x unsigned.
- `x`  in  32: multiplicand.
- `y`  in  32: multiplier, the Booth-recoded operand.
- `flush`  in  1: cancels the held result and any same-cycle acceptance.
- `out_valid`  out  1: pp_col is valid.
- `out_ready`  in  1: downstream (the Wallace stage) accepts.
- `pp_col`  out  PROD_W*PP_NUM: column j occupies bits [17j+16:17j]. Bit i of column j is bit j of partial product i.

## Operation
- Extension:
  - x_ext[63:0] = x extended to 64 bits. Sign-extend if mul_signed, else zero-extend.
  - y_ext[33:0] = {2{mul_signed & y[31]}, y}. Define y_ext[-1] = 0.
- Booth groups i = 0..16 use code = {y_ext[2i+1], y_ext[2i], y_ext[2i-1]}.
  - 000 and 111: mag = 0, neg = 0.
  - 001 and 010: mag = x_ext, neg = 0.
  - 011: mag = x_ext<<1, neg = 0.
  - 100: mag = x_ext<<1, neg = 1.
  - 101 and 110: mag = x_ext, neg = 1.
- Partial product: pp_i = (({64{neg_i}} ^ mag_i) << 2i), truncated to 64 bits. Bits [2i-1:0] are zero.
- Negation folding: for i = 0..15, bit 2i of pp_{i+1} is forced to neg_i. That bit is otherwise zero.
  - neg_16 is always 0 by construction.
  - Signed group 16 is 000 or 111. Unsigned group 16 is 000 or 001.
  - An internal assertion must flag neg_16 = 1.
- Invariant: sum over i of pp_i, mod 2^64, equals the 64-bit product x*y under the selected signedness.
- Pipeline: one output register stage holding pp_col, with out_valid.
  - in_ready = !out_valid || out_ready. This is combinational and has no bubble.
  - Accept when in_valid && in_ready && !flush. On accept, the register loads next cycle and out_valid = 1.
  - The held value is released on out_valid && out_ready. If there is no new accept that cycle, out_valid goes to 0.
  - When out_valid && !out_ready, pp_col and out_valid hold stable. Inputs are ignored.
- Flush: the next cycle has out_valid = 0, and no operand is accepted in the flush cycle. Flush has priority over acceptance and over hold.

## Timing
- Latency is 1 cycle from an accepting edge to out_valid = 1.
- Throughput is 1 operation per cycle when out_ready = 1.
- Reset values: out_valid = 0 and pp_col = 0 immediately on resetn falling. in_ready = 1 while in reset.
- Reset asserted mid-operation discards the held result. No output is produced for it after release.
- Simultaneous release and accept: the register is overwritten with the new result and out_valid stays 1.
- pp_col is a register output. in_ready depends combinationally only on out_valid and out_ready.

## Structure
- Package `mul_pkg`:
  - constants XW, PP_NUM, PROD_W;
  - Booth code localparams or enum (ZERO, POS1, POS2, NEG2, NEG1);
  - column-index helper function.
- Sub-module `booth_sel`:
  - one per group, instantiated 17 times with a generate loop;
  - inputs are the 3-bit code and x_ext; outputs are mag_sel[63:0] and neg;
  - purely combinational.
- Top level: extension, shifting and folding, transpose, output register, handshake.

## Test plan
- Unsigned x=3, y=5, out_ready=1 → out_valid 1 cycle later; column sum = 0x000000000000000F.
- Signed x=0xFFFFFFFF, y=0xFFFFFFFF → sum = 1. Unsigned, same operands → sum = 0xFFFFFFFE00000001.
- Signed x=0x80000000, y=0x80000000 → sum = 0x4000000000000000. neg_16 assertion is never triggered.
- out_ready=0 for 3 cycles while in_valid=1:
  - in_ready=0 and pp_col is stable;
  - when out_ready rises, the next operand is accepted the same cycle and there is no loss or duplication.
- flush=1 while out_valid=1 and in_valid=1 → next cycle out_valid=0, and that operand is not accepted.
- resetn pulsed low mid-stream → out_valid and pp_col read 0 asynchronously. The first result after release comes from the first post-reset accept only.
- Random regression of 10k pairs, both signedness modes, with a random out_ready → every column-sum equals the reference product.
